// File: rtl/mc_pkg.sv
// Shared opcode values, state encodings and datapath mux-select constants
// for the multi-cycle control sequencer.
package mc_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_BEQ = 3'd2;
    localparam logic [2:0] OP_BLT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_OR  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic PC_SEL_INC    = 1'b0;
    localparam logic PC_SEL_BRANCH = 1'b1;
    localparam logic WB_SEL_ALU    = 1'b0;
    localparam logic WB_SEL_MEM    = 1'b1;
    localparam logic ADDR_SEL_PC   = 1'b0;
    localparam logic ADDR_SEL_ALU  = 1'b1;

    // Register-register ALU ops occupy the upper half of the opcode space.
    function automatic logic is_alu_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_branch_op(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BLT);
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait timer: counts consecutive stalled request cycles and flags a
// timeout on the MEM_TIMEOUT-th stalled cycle.
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic active,
    input  logic memReady,
    output logic timeout
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // A completing memReady clears the count and suppresses the timeout in the same cycle.
    always_comb begin
        count_d = '0;
        timeout = 1'b0;
        if (active && !memReady) begin
            count_d = count_q + 1'b1;
            if (count_q == TW'(MEM_TIMEOUT - 1)) begin
                timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with memory
// timeout detection and a retired-instruction counter.
//
//  state  | meaning
//  IDLE   | parked, waiting for run
//  FETCH  | instruction read from PC; IR and PC+4 loaded on memReady
//  DECODE | regfile outputs latched into A/B, opcode captured
//  EXEC   | ALU op, branch resolve, or address calculation
//  MEM    | data read (LW) or write (SW) at ALUOut
//  WB     | regfile write from ALUOut or memory data
//  ERROR  | memory timeout; left only by reset
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             updatePC,
    input  logic             memReady,
    output logic             memRead,
    output logic             memWrite,
    output logic             memAddrSel,
    output logic             irWrite,
    output logic             abWrite,
    output logic [2:0]       aluOpcode,
    output logic             aluSrcBSel,
    output logic             aluOutWrite,
    output logic             pcWrite,
    output logic             pcSel,
    output logic             regWrite,
    output logic             wbSel,
    output logic             busError,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             busError_q, busError_d;
    logic             timer_active;
    logic             timeout;
    logic             retire;

    assign timer_active = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mc_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timer (
        .clk     (clk),
        .resetN  (resetN),
        .active  (timer_active),
        .memReady(memReady),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            retired_q  <= '0;
            busError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            retired_q  <= retired_d;
            busError_q <= busError_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        retired_d   = retired_q;
        busError_d  = busError_q;
        retire      = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memAddrSel  = ADDR_SEL_PC;
        irWrite     = 1'b0;
        abWrite     = 1'b0;
        aluOpcode   = 3'd0;
        aluSrcBSel  = 1'b0;
        aluOutWrite = 1'b0;
        pcWrite     = 1'b0;
        pcSel       = PC_SEL_INC;
        regWrite    = 1'b0;
        wbSel       = WB_SEL_ALU;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                memRead    = 1'b1;
                memAddrSel = ADDR_SEL_PC;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    pcSel   = PC_SEL_INC;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                abWrite = 1'b1;
                op_d    = opcode;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(op_q)) begin
                    aluOpcode   = op_q;
                    aluOutWrite = 1'b1;
                    state_d     = ST_WB;
                end else if (is_branch_op(op_q)) begin
                    aluOpcode = op_q;
                    if (updatePC) begin
                        pcWrite = 1'b1;
                        pcSel   = PC_SEL_BRANCH;
                    end
                    retire = 1'b1;
                end else begin
                    // Loads and stores use the ALU to form base + immediate.
                    aluOpcode   = OP_ADD;
                    aluSrcBSel  = 1'b1;
                    aluOutWrite = 1'b1;
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                memAddrSel = ADDR_SEL_ALU;
                if (op_q == OP_LW) memRead  = 1'b1;
                else               memWrite = 1'b1;
                if (memReady) begin
                    if (op_q == OP_LW) state_d = ST_WB;
                    else               retire  = 1'b1;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                regWrite = 1'b1;
                wbSel    = (op_q == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                retire   = 1'b1;
            end
            ST_ERROR: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + 1'b1;
            state_d   = run ? ST_FETCH : ST_IDLE;
        end

        if (timeout) busError_d = 1'b1;
    end

    assign busError = busError_q;
    assign retired  = retired_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its
// expected per-cycle output trace and compared against the DUT cycle by cycle.
module tb_mc_control_fsm;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    localparam logic [2:0] T_LW  = 3'd0;
    localparam logic [2:0] T_SW  = 3'd1;
    localparam logic [2:0] T_BEQ = 3'd2;
    localparam logic [2:0] T_BLT = 3'd3;
    localparam logic [2:0] T_ADD = 3'd4;

    logic             clk = 1'b0;
    logic             resetN, run, updatePC, memReady;
    logic [2:0]       opcode;
    logic             memRead, memWrite, memAddrSel, irWrite, abWrite;
    logic [2:0]       aluOpcode;
    logic             aluSrcBSel, aluOutWrite, pcWrite, pcSel, regWrite, wbSel, busError;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    mc_control_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .run        (run),
        .opcode     (opcode),
        .updatePC   (updatePC),
        .memReady   (memReady),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memAddrSel (memAddrSel),
        .irWrite    (irWrite),
        .abWrite    (abWrite),
        .aluOpcode  (aluOpcode),
        .aluSrcBSel (aluSrcBSel),
        .aluOutWrite(aluOutWrite),
        .pcWrite    (pcWrite),
        .pcSel      (pcSel),
        .regWrite   (regWrite),
        .wbSel      (wbSel),
        .busError   (busError),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mr, mw, mas, irw, abw;
        logic [2:0] alu;
        logic       srcb, aow, pcw, pcs, rw, wbs, berr;
    } obs_t;

    obs_t obs;
    assign obs = {state, memRead, memWrite, memAddrSel, irWrite, abWrite, aluOpcode,
                  aluSrcBSel, aluOutWrite, pcWrite, pcSel, regWrite, wbSel, busError};

    int          checks   = 0;
    int          failures = 0;
    int          cyc_no   = 0;
    int unsigned exp_ret  = 0;
    logic        exp_berr = 1'b0;
    bit          at_idle  = 1'b1;
    bit          aborted  = 1'b0;
    int          abort_in = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc_no, got, want);
        end
    endtask

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e;
        e      = '0;
        e.st   = st;
        e.berr = exp_berr;
        return e;
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, update the model on reset.
    task automatic cyc(input obs_t e, input logic rdy, input logic upd, input logic run_i,
                       input logic [2:0] op_i, input logic rst_req_n);
        logic rst_n;
        rst_n = rst_req_n;
        if (abort_in > 0) begin
            abort_in--;
            if (abort_in == 0) rst_n = 1'b0;
        end
        @(negedge clk);
        resetN   = rst_n;
        memReady = rdy;
        updatePC = upd;
        run      = run_i;
        opcode   = op_i;
        #1;
        cyc_no++;
        check_eq("outputs", 32'(obs), 32'(e));
        check_eq("retired", 32'(retired), exp_ret % (32'd1 << CNT_W));
        if (!rst_n) begin
            aborted  = 1'b1;
            exp_ret  = 0;
            exp_berr = 1'b0;
            at_idle  = 1'b1;
        end
    endtask

    task automatic retire_cyc(input obs_t e, input logic rdy, input logic upd,
                              input logic run_next, input logic [2:0] op);
        cyc(e, rdy, upd, run_next, op, 1'b1);
        if (!aborted) begin
            exp_ret++;
            at_idle = !run_next;
        end
    endtask

    task automatic enter_error();
        obs_t e;
        exp_berr = 1'b1;
        repeat ($urandom_range(1, 4)) begin
            e = blank(3'd6);
            cyc(e, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b1);
            if (aborted) return;
        end
        e = blank(3'd6);
        cyc(e, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
    endtask

    task automatic idle_cycles();
        repeat ($urandom_range(0, 2))
            cyc(blank(3'd0), 1'($urandom), 1'($urandom), 1'b0, 3'($urandom), 1'b1);
        cyc(blank(3'd0), 1'($urandom), 1'($urandom), 1'b1, 3'($urandom), 1'b1);
        at_idle = 1'b0;
    endtask

    // fw/mw: stalled cycles before memReady in FETCH/MEM; >= MEM_TIMEOUT means it never comes.
    task automatic do_instr(input logic [2:0] op, input int fw, input int mw,
                            input logic upd, input logic run_next);
        obs_t e;
        for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) begin
            e = blank(3'd1); e.mr = 1'b1;
            cyc(e, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'b1);
            if (aborted) return;
        end
        if (fw >= MEM_TIMEOUT) begin enter_error(); return; end
        e = blank(3'd1); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(e, 1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 1'b1);
        if (aborted) return;
        e = blank(3'd2); e.abw = 1'b1;
        cyc(e, 1'($urandom), 1'($urandom), 1'($urandom), op, 1'b1);
        if (aborted) return;

        e = blank(3'd3);
        if (op == T_BEQ || op == T_BLT) begin
            e.alu = op; e.pcw = upd; e.pcs = upd;
            retire_cyc(e, 1'($urandom), upd, run_next, op);
            return;
        end
        if (op >= T_ADD) begin
            e.alu = op; e.aow = 1'b1;
            cyc(e, 1'($urandom), 1'($urandom), 1'($urandom), op, 1'b1);
            if (aborted) return;
        end else begin
            e.alu = T_ADD; e.srcb = 1'b1; e.aow = 1'b1;
            cyc(e, 1'($urandom), 1'($urandom), 1'($urandom), op, 1'b1);
            if (aborted) return;
            e = blank(3'd4); e.mas = 1'b1; e.mr = (op == T_LW); e.mw = (op == T_SW);
            for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) begin
                cyc(e, 1'b0, 1'($urandom), 1'($urandom), op, 1'b1);
                if (aborted) return;
            end
            if (mw >= MEM_TIMEOUT) begin enter_error(); return; end
            if (op == T_SW) begin
                retire_cyc(e, 1'b1, 1'($urandom), run_next, op);
                return;
            end
            cyc(e, 1'b1, 1'($urandom), 1'($urandom), op, 1'b1);
            if (aborted) return;
        end
        e = blank(3'd5); e.rw = 1'b1; e.wbs = (op == T_LW);
        retire_cyc(e, 1'($urandom), 1'($urandom), run_next, op);
    endtask

    task automatic run_one(input logic [2:0] op, input int fw, input int mw,
                           input logic upd, input logic run_next, input int abort_at);
        aborted = 1'b0;
        if (at_idle) idle_cycles();
        abort_in = abort_at;
        do_instr(op, fw, mw, upd, run_next);
        abort_in = 0;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return MEM_TIMEOUT;
        if (r < 24) return 0;
        return $urandom_range(1, MEM_TIMEOUT - 1);
    endfunction

    initial begin
        resetN = 1'b0; run = 1'b0; updatePC = 1'b0; memReady = 1'b0; opcode = 3'd0;
        repeat (2) @(posedge clk);

        cyc(blank(3'd0), 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        run_one(T_ADD, 0, 0, 1'b0, 1'b1, 0);
        run_one(T_BEQ, 0, 0, 1'b1, 1'b1, 0);
        run_one(T_BLT, 0, 0, 1'b0, 1'b1, 0);
        run_one(T_LW,  0, 3, 1'b0, 1'b1, 0);
        run_one(3'd6,  MEM_TIMEOUT - 1, 0, 1'b0, 1'b1, 0);
        run_one(T_SW,  MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 1'b1, 0);
        run_one(T_SW,  0, 2, 1'b0, 1'b1, 4);
        for (int i = 0; i < 20; i++) run_one(3'd5, 0, 0, 1'b0, 1'b1, 0);
        run_one(T_LW,  0, 0, 1'b0, 1'b0, 0);
        run_one(3'd7,  MEM_TIMEOUT, 0, 1'b0, 1'b1, 0);
        run_one(T_LW,  0, MEM_TIMEOUT, 1'b0, 1'b1, 0);

        for (int n = 0; n < 300; n++) begin
            run_one(3'($urandom), pick_wait(), pick_wait(), 1'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 6)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
